// File: rtl/uno_scale_apply.sv
// uno_scale_apply: rescales a raw unary/PE result by a signed fixed-point scale.
//   gemm : result passes through unchanged
//   log  : result + scale (one extra bit of headroom, then fitted to MUL_BW)
//   div/exp : (|res| * |scale|) >> FRA_BW on magnitudes, sign reapplied, then fitted
// The multiply is a serial shift-add: one multiplier bit per MUL cycle.
// Build option: define UNO_SAT_EN to clip out-of-range results to the signed
// MUL_BW bounds (sat_o flags a clip); without it results wrap to the low MUL_BW bits.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high; the producer holds data stable while valid && !ready. in_ready is high only
// in IDLE, out_valid only in DONE, so one operation is in flight and the output
// handshake cycle never doubles as an accept.
module uno_scale_apply #(
    parameter int MUL_BW = 16,
    parameter int FRA_BW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        gemm_uno,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_BW-1:0] res_i,
    input  logic [MUL_BW-1:0] scale_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MUL_BW-1:0] out_o,
    output logic              sat_o,
    output logic [1:0]        o_dbg_state
);
    localparam int PW = 2 * MUL_BW;
    localparam int QW = PW - FRA_BW;
    localparam int XW = PW + 2;
    localparam int CW = (MUL_BW > 1) ? $clog2(MUL_BW) : 1;
    localparam logic [1:0] OP_LOG = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_mul_op;
    logic              w_last;
    logic [CW-1:0]     r_cnt;
    logic              r_neg;
    logic [MUL_BW-1:0] r_mplier;
    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     w_acc_next;
    logic [MUL_BW-1:0] w_res_mag;
    logic [MUL_BW-1:0] w_scale_mag;
    logic [QW-1:0]     w_prod_q;
    logic [XW-1:0]     w_prod_ext;
    logic [XW-1:0]     w_mul_wide;
    logic [MUL_BW:0]   w_log_sum;
    logic [MUL_BW-1:0] w_mul_res;
    logic [MUL_BW-1:0] w_log_res;
    logic [MUL_BW-1:0] r_out;

    // div (01) and exp (10) are the two ops that need the multiplier
    assign w_mul_op = gemm_uno[1] ^ gemm_uno[0];
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CW'(MUL_BW - 1));

    // Unsigned magnitudes; the most negative input maps to 2^(MUL_BW-1) without overflow
    assign w_res_mag   = res_i[MUL_BW-1]   ? (~res_i + MUL_BW'(1))   : res_i;
    assign w_scale_mag = scale_i[MUL_BW-1] ? (~scale_i + MUL_BW'(1)) : scale_i;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Truncate the fractional bits on the magnitude, then reapply the sign
    assign w_prod_q   = w_acc_next[PW-1:FRA_BW];
    assign w_prod_ext = {{(XW - QW){1'b0}}, w_prod_q};
    assign w_mul_wide = r_neg ? (~w_prod_ext + XW'(1)) : w_prod_ext;

    // log sum carries one extra bit so the true sum is always representable
    assign w_log_sum = {res_i[MUL_BW-1], res_i} + {scale_i[MUL_BW-1], scale_i};

`ifdef UNO_SAT_EN
    localparam logic [XW-1:0] LIM_HI = {{(XW - MUL_BW + 1){1'b0}}, {(MUL_BW - 1){1'b1}}};
    localparam logic [XW-1:0] LIM_LO = {{(XW - MUL_BW + 1){1'b1}}, {(MUL_BW - 1){1'b0}}};

    logic          w_mul_sat;
    logic          w_log_sat;
    logic [XW-1:0] w_log_wide;
    logic          r_sat;

    function automatic logic [MUL_BW:0] clip(input logic [XW-1:0] v);
        if ($signed(v) > $signed(LIM_HI)) begin
            clip = {1'b1, LIM_HI[MUL_BW-1:0]};
        end else if ($signed(v) < $signed(LIM_LO)) begin
            clip = {1'b1, LIM_LO[MUL_BW-1:0]};
        end else begin
            clip = {1'b0, v[MUL_BW-1:0]};
        end
    endfunction

    assign w_log_wide              = {{(XW - MUL_BW - 1){w_log_sum[MUL_BW]}}, w_log_sum};
    assign {w_mul_sat, w_mul_res}  = clip(w_mul_wide);
    assign {w_log_sat, w_log_res}  = clip(w_log_wide);

    // Saturation flag updates only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (w_accept && !w_mul_op) begin
            r_sat <= (gemm_uno == OP_LOG) ? w_log_sat : 1'b0;
        end else if (r_state == S_MUL && w_last) begin
            r_sat <= w_mul_sat;
        end
    end

    assign sat_o = r_sat;
`else
    logic w_unused_hi;

    assign w_mul_res   = w_mul_wide[MUL_BW-1:0];
    assign w_log_res   = w_log_sum[MUL_BW-1:0];
    assign w_unused_hi = ^{w_mul_wide[XW-1:MUL_BW], w_log_sum[MUL_BW]};
    assign sat_o       = 1'b0;
`endif

    // Operand capture on accept, then one multiplier bit consumed per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_neg    <= res_i[MUL_BW-1] ^ scale_i[MUL_BW-1];
            r_mplier <= w_scale_mag;
            r_mcand  <= {{MUL_BW{1'b0}}, w_res_mag};
            r_acc    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= w_last ? '0 : (r_cnt + CW'(1));
        end
    end

    // Result register loads only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_accept && !w_mul_op) begin
            r_out <= (gemm_uno == OP_LOG) ? w_log_res : res_i;
        end else if (r_state == S_MUL && w_last) begin
            r_out <= w_mul_res;
        end
    end

    assign out_o = r_out;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: multiply ops detour through MUL, the others go straight to DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = w_mul_op ? S_MUL : S_DONE;
            S_MUL:   if (w_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake flags are pure functions of state
    always_comb begin
        in_ready    = (r_state == S_IDLE);
        out_valid   = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_uno_scale_apply.sv
// Bench for uno_scale_apply (MUL_BW=16, FRA_BW=10): directed and random ops
// against an integer-arithmetic reference, plus hold and mid-operation reset.
module tb_uno_scale_apply;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   gemm_uno = 2'b00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] res_i = '0;
    logic [W-1:0] scale_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_o;
    logic         sat_o;
    logic [1:0]   o_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    uno_scale_apply #(.MUL_BW(16), .FRA_BW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gemm_uno   (gemm_uno),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_i      (res_i),
        .scale_i    (scale_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_o      (out_o),
        .sat_o      (sat_o),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: {sat, out} from plain signed integer arithmetic
    function automatic logic [W:0] ref_model(input logic [1:0] op, input logic [W-1:0] r,
                                             input logic [W-1:0] s);
        longint rv;
        longint sv;
        longint m;
        longint v;
        rv = longint'($signed(r));
        sv = longint'($signed(s));
        if (op == 2'b00) return {1'b0, r};
        if (op == 2'b11) begin
            v = rv + sv;
        end else begin
            m = ((rv < 0 ? -rv : rv) * (sv < 0 ? -sv : sv)) / 1024;
            v = ((rv < 0) != (sv < 0)) ? -m : m;
        end
`ifdef UNO_SAT_EN
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, v[W-1:0]};
    endfunction

    function automatic int ref_latency(input logic [1:0] op);
        return (op == 2'b01 || op == 2'b10) ? 17 : 1;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h8000;
            1:       v = 16'h7FFF;
            2:       v = 16'h0400;
            3:       v = 16'hFC00;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // Driver: present one op, measure edges from accept to out_valid, capture, then drain
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] r, input logic [W-1:0] s,
                          input int hold, output logic [W-1:0] o, output logic sat,
                          output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        gemm_uno = op;
        res_i    = r;
        scale_i  = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gemm_uno = 2'($urandom);
        res_i    = 16'($urandom);
        scale_i  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        o   = out_o;
        sat = sat_o;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_vec++;
        if (out_o !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_out_o got=%h want=0000", out_o);
        end
        n_vec++;
        if (sat_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sat_o got=%b want=0", sat_o);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   ops[9]  = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11};
        logic [W-1:0] rs[9]   = '{16'h0600, 16'h0400, 16'hFC00, 16'h7FFF, 16'h7F00,
                                  16'h8000, 16'h8000, 16'h8000, 16'h1234};
        logic [W-1:0] ss[9]   = '{16'h1000, 16'hFE00, 16'hFE00, 16'h7FFF, 16'h0200,
                                  16'h1234, 16'h8000, 16'h8000, 16'hF000};
        logic [W-1:0] o;
        logic         sat;
        int           lat;
        logic [W:0]   exp_v;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], rs[i], ss[i], i % 3, o, sat, lat);
            exp_v = ref_model(ops[i], rs[i], ss[i]);
            n_vec++;
            if (o !== exp_v[W-1:0]) begin
                n_err++;
                $display("FAIL dir%0d_out op=%b got=%h want=%h", i, ops[i], o, exp_v[W-1:0]);
            end
            n_vec++;
            if (sat !== exp_v[W]) begin
                n_err++;
                $display("FAIL dir%0d_sat got=%b want=%b", i, sat, exp_v[W]);
            end
            n_vec++;
            if (lat !== ref_latency(ops[i])) begin
                n_err++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, ref_latency(ops[i]));
            end
            // Worked examples that hold in either build
            if (i == 0) begin
                n_vec++;
                if (o !== 16'h1800 || lat !== 17) begin
                    n_err++;
                    $display("FAIL exp_example got=%h/%0d want=1800/17", o, lat);
                end
            end
            if (i == 1 || i == 2) begin
                n_vec++;
                if (o !== ((i == 1) ? 16'hFE00 : 16'h0200)) begin
                    n_err++;
                    $display("FAIL div_example%0d got=%h want=%h", i, o,
                             (i == 1) ? 16'hFE00 : 16'h0200);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic [W-1:0] o;
        logic         sat;
        int           lat;
        logic [W:0]   exp_v;
        logic [W:0]   exp_q[$];
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            r  = pick_operand();
            s  = pick_operand();
            exp_q.push_back(ref_model(op, r, s));
            run_op(op, r, s, $urandom_range(0, 2), o, sat, lat);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({sat, o} !== exp_v) begin
                n_err++;
                $display("FAIL rnd%0d op=%b res=%h scale=%h got=%b/%h want=%b/%h",
                         i, op, r, s, sat, o, exp_v[W], exp_v[W-1:0]);
            end
            n_vec++;
            if (lat !== ref_latency(op)) begin
                n_err++;
                $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ref_latency(op));
            end
        end
    endtask

    // Output stalled 5 cycles while a competing request is held at the input
    task automatic test_hold();
        @(negedge clk);
        gemm_uno = 2'b00;
        res_i    = 16'h1234;
        scale_i  = 16'h0777;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        res_i = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (out_o !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0 || sat_o !== 1'b0) begin
                n_err++;
                $display("FAIL hold_c%0d got out=%h v=%b rdy=%b sat=%b want 1234/1/0/0",
                         c, out_o, out_valid, in_ready, sat_o);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic         seen;
        logic [W-1:0] o;
        logic         sat;
        int           lat;
        logic [W:0]   exp_v;
        @(negedge clk);
        gemm_uno = 2'b10;
        res_i    = 16'h0600;
        scale_i  = 16'h1000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_async got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        n_vec++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_discard got seen_valid=%b rdy=%b want 0/1", seen, in_ready);
        end
        run_op(2'b01, 16'hFC00, 16'hFE00, 0, o, sat, lat);
        exp_v = ref_model(2'b01, 16'hFC00, 16'hFE00);
        n_vec++;
        if ({sat, o} !== exp_v || lat !== 17) begin
            n_err++;
            $display("FAIL midrst_next got=%b/%h/%0d want=%b/%h/17",
                     sat, o, lat, exp_v[W], exp_v[W-1:0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uno_scale_apply.md
UNO_SCALE_APPLY -- requirements
Module: uno_scale_apply

Interface
REQ-001 SHALL have parameter MUL_BW, default 16, data width of result, scale and output.
REQ-002 SHALL have parameter FRA_BW, default 10, fractional bits of the fixed-point format.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gemm_uno  input  2  op: 00 gemm, 01 div, 10 exp, 11 log; sampled at accept.
REQ-006 SHALL have port in_valid  input  1  res_i/scale_i/gemm_uno valid.
REQ-007 SHALL have port in_ready  output  1  block can accept; high only in IDLE.
REQ-008 SHALL have port res_i  input  MUL_BW  signed raw unary/PE result.
REQ-009 SHALL have port scale_i  input  MUL_BW  signed scale from the scale generator.
REQ-010 SHALL have port out_valid  output  1  out_o/sat_o valid; high only in DONE.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output.
REQ-012 SHALL have port out_o  output  MUL_BW  signed rescaled result.
REQ-013 SHALL have port sat_o  output  1  result was clipped.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 Accept SHALL occur on a rising edge with in_valid && in_ready; operands and op are registered then.
REQ-016 IDLE SHALL go to MUL for div/exp, to DONE for gemm/log, and stay IDLE without accept.
REQ-017 gemm SHALL pass res_i to out_o unchanged, sat_o=0.
REQ-018 log SHALL output res_i + scale_i, computed at MUL_BW+1 bits, then clipped per REQ-024.
REQ-019 div/exp SHALL compute (|res_i| * |scale_i|) >> FRA_BW, truncated on magnitude, negated if sign(res_i) xor sign(scale_i), then clipped per REQ-024.
REQ-020 The multiply SHALL be iterative shift-add, one multiplier bit per cycle, a 0..MUL_BW-1 counter, exactly MUL_BW cycles in MUL; then DONE.
REQ-021 Latency: for gemm/log, out_valid SHALL be high after the first edge following accept; for div/exp, after MUL_BW+1 edges.
REQ-022 DONE SHALL hold out_o, sat_o, out_valid stable until out_ready is high on an edge, then go to IDLE.
REQ-023 in_ready SHALL be low in MUL and DONE; no new accept in the same cycle as output handshake (one-deep, no bypass).
REQ-024 Clipping per Configuration; magnitude of -2^(MUL_BW-1) SHALL be handled without overflow (unsigned MUL_BW magnitude).
REQ-025 out_o and sat_o SHALL change only on the edge entering DONE.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, counter 0, out_o 0, sat_o 0, out_valid 0, in_ready 1 after release.
REQ-027 Reset mid-MUL or mid-DONE SHALL discard the operation; no output handshake occurs for it.

Configuration
REQ-028 Macro UNO_SAT_EN defined: results above 2^(MUL_BW-1)-1 or below -2^(MUL_BW-1) SHALL clip to those bounds with sat_o=1 for that result.
REQ-029 UNO_SAT_EN undefined: result SHALL be the low MUL_BW bits (two's-complement wrap), sat_o tied 0, clip logic absent.

Verification (MUL_BW=16, FRA_BW=10, 1.0=0x0400)
REQ-030 exp: res_i=0x0600, scale_i=0x1000 accepted -> out_o=0x1800, sat_o=0, out_valid 17 edges after accept.
REQ-031 div signed: res_i=0x0400, scale_i=0xFE00 -> out_o=0xFE00; res_i=0xFC00, scale_i=0xFE00 -> 0x0200.
REQ-032 overflow: exp res_i=0x7FFF, scale_i=0x7FFF -> with UNO_SAT_EN 0x7FFF, sat_o=1; without 0xFFC0, sat_o=0; log res_i=0x7F00, scale_i=0x0200 -> 0x7FFF, sat_o=1 (with macro).
REQ-033 gemm res_i=0x1234 with out_ready low 5 cycles -> out_o=0x1234 held stable, out_valid high, in_ready low throughout; IDLE one edge after out_ready.
REQ-034 rst_n pulsed low in MUL cycle 8 -> out_valid never asserts for that op, in_ready=1 after release, next op returns the correct result.
